ahb_slave_decoder: RTL and testbench

Parametrised AHB-Lite address decoder and slave response multiplexer for the bus interconnect. It decodes a configurable slave-select field of `HADDR` into one-hot `HSEL` lines for up to `2**SEL_LEN` slaves. It tracks the data phase with a registered select, and routes the selected slave's `HRDATA`/`HREADYOUT`/`HRESP` back to the master. Unmapped selects are served by an optional built-in default slave that returns a two-cycle ERROR response.

---
 rtl/ahb_slave_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_ahb_slave_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_decoder.sv
// -----------------------------------------------------------------------------
// ahb_slave_decoder
//
// Purpose:
//   AHB-Lite address decoder and slave response multiplexer. A select field of
//   HADDR is decoded into one-hot HSEL lines during the address phase. The
//   target is registered on each accepted transfer (HREADY=1), and the
//   registered select routes the chosen slave's HRDATA/HREADYOUT/HRESP back to
//   the master during the data phase.
//
// Optional feature (macro AHB_DECODER_DEFAULT_SLAVE_EN):
//   Defined   - a built-in default slave serves unmapped select codes. An
//               unmapped NONSEQ/SEQ gets a two-cycle ERROR response. An
//               unmapped IDLE/BUSY completes with OKAY and no wait states.
//   Undefined - unmapped codes alias to slave 0. The data-phase select resets
//               to slave 0.
//
// Ports:
//   HCLK        in  1                      bus clock, rising edge
//   HRESET      in  1                      asynchronous active-high reset
//   HADDR       in  ADDR_WIDTH             master address (address phase)
//   HTRANS      in  2                      transfer type; bit 1 = NONSEQ/SEQ
//   HSEL        out NUM_SLAVES             one-hot slave select (combinational)
//   HRDATA_S    in  NUM_SLAVES*DATA_WIDTH  slave read data, slave i at
//                                          [i*DATA_WIDTH +: DATA_WIDTH]
//   HREADYOUT_S in  NUM_SLAVES             per-slave ready
//   HRESP_S     in  NUM_SLAVES             per-slave response (1 = ERROR)
//   HRDATA      out DATA_WIDTH             muxed read data
//   HREADY      out 1                      muxed ready to master and slaves
//   HRESP       out 1                      muxed response
// -----------------------------------------------------------------------------
module ahb_slave_decoder #(
    parameter int NUM_SLAVES = 3,
    parameter int SEL_LEN    = 2,
    parameter int SEL_LSB    = 30,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    output logic [NUM_SLAVES-1:0]            HSEL,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HREADY,
    output logic                             HRESP
);

`ifdef AHB_DECODER_DEFAULT_SLAVE_EN
    // The default slave occupies the extra top entry of the data-phase select.
    localparam int DSEL_W  = NUM_SLAVES + 1;
    localparam int RST_IDX = NUM_SLAVES;
`else
    localparam int DSEL_W  = NUM_SLAVES;
    localparam int RST_IDX = 0;
`endif

    localparam logic [DSEL_W-1:0]  DSEL_RST     = DSEL_W'(1) << RST_IDX;
    // Slave count widened by one bit so that NUM_SLAVES == 2**SEL_LEN still fits.
    localparam logic [SEL_LEN:0]   NUM_SLAVES_W = (SEL_LEN + 1)'(NUM_SLAVES);

    logic [SEL_LEN-1:0]    w_code;
    logic                  w_mapped;
    logic [NUM_SLAVES-1:0] w_hsel;
    logic [DSEL_W-1:0]     w_dsel_dec;
    logic [DSEL_W-1:0]     r_dsel;
    logic [DATA_WIDTH-1:0] w_hrdata;
    logic                  w_hready;
    logic                  w_hresp;
    logic                  w_unused;

    // Only the select field of HADDR and HTRANS[1] carry meaning here.
    assign w_unused = ^{HADDR, HTRANS};

    assign w_code   = HADDR[SEL_LSB +: SEL_LEN];
    assign w_mapped = ({1'b0, w_code} < NUM_SLAVES_W);

    // Address-phase decode of the select code into one-hot HSEL.
    always_comb begin
        w_hsel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_hsel[i] = w_mapped && (w_code == SEL_LEN'(i));
        end
`ifndef AHB_DECODER_DEFAULT_SLAVE_EN
        // Without a default slave, unmapped space aliases onto slave 0.
        w_hsel[0] = w_hsel[0] | ~w_mapped;
`endif
    end

    assign HSEL = w_hsel;

`ifdef AHB_DECODER_DEFAULT_SLAVE_EN
    assign w_dsel_dec = {~w_mapped, w_hsel};
`else
    assign w_dsel_dec = w_hsel;
`endif

    // Data-phase select: captures the decoded target on each accepted transfer.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_dsel <= DSEL_RST;
        end else if (w_hready) begin
            r_dsel <= w_dsel_dec;
        end else begin
            r_dsel <= r_dsel;
        end
    end

`ifdef AHB_DECODER_DEFAULT_SLAVE_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } def_state_t;

    def_state_t r_state;
    def_state_t w_state_next;
    logic       w_def_hready;
    logic       w_def_hresp;
    logic       w_err_accept;

    // An unmapped NONSEQ/SEQ accepted this edge starts a new error response.
    assign w_err_accept = w_hready & ~w_mapped & HTRANS[1];

    // Default-slave state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Default-slave response outputs, decoded from the current state only.
    // Kept apart from next-state logic so HREADY feeds back without a loop.
    always_comb begin
        w_def_hready = 1'b1;
        w_def_hresp  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_def_hready = 1'b1;
                w_def_hresp  = 1'b0;
            end
            ST_ERR1: begin
                w_def_hready = 1'b0;
                w_def_hresp  = 1'b1;
            end
            ST_ERR2: begin
                w_def_hready = 1'b1;
                w_def_hresp  = 1'b1;
            end
            default: begin
                w_def_hready = 1'b1;
                w_def_hresp  = 1'b0;
            end
        endcase
    end

    // Default-slave next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_err_accept) begin
                    w_state_next = ST_ERR1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ERR1: begin
                // HREADY is low here, so nothing can be accepted.
                w_state_next = ST_ERR2;
            end
            ST_ERR2: begin
                if (w_err_accept) begin
                    w_state_next = ST_ERR1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end
`endif

    // Data-phase response mux: AND-OR of all sources gated by the one-hot select.
    always_comb begin
        w_hrdata = '0;
        w_hready = 1'b0;
        w_hresp  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_hrdata = w_hrdata | (HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_dsel[i]}});
            w_hready = w_hready | (HREADYOUT_S[i] & r_dsel[i]);
            w_hresp  = w_hresp  | (HRESP_S[i]     & r_dsel[i]);
        end
`ifdef AHB_DECODER_DEFAULT_SLAVE_EN
        // The default slave returns zero data, so it only adds ready/response.
        w_hready = w_hready | (w_def_hready & r_dsel[NUM_SLAVES]);
        w_hresp  = w_hresp  | (w_def_hresp  & r_dsel[NUM_SLAVES]);
`endif
    end

    assign HRDATA = w_hrdata;
    assign HREADY = w_hready;
    assign HRESP  = w_hresp;

endmodule

// File: tb/tb_ahb_slave_decoder.sv
// -----------------------------------------------------------------------------
// tb_ahb_slave_decoder
//
// Directed bench for ahb_slave_decoder with default parameters. Expected
// values are hand-computed. Where the two builds differ (default slave
// present or not), the expectation is chosen from the same macro.
// -----------------------------------------------------------------------------
module tb_ahb_slave_decoder;

`ifdef AHB_DECODER_DEFAULT_SLAVE_EN
    localparam bit DEF_EN = 1'b1;
`else
    localparam bit DEF_EN = 1'b0;
`endif

    localparam logic [31:0] S0_DATA = 32'h1111_0000;
    localparam logic [31:0] S1_DATA = 32'hA5A5_0001;
    localparam logic [31:0] S2_DATA = 32'h2222_0002;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSEL;
    logic [95:0] HRDATA_S;
    logic [2:0]  HREADYOUT_S;
    logic [2:0]  HRESP_S;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int checks = 0;
    int errors = 0;

    ahb_slave_decoder dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSEL        (HSEL),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    assign HRDATA_S = {S2_DATA, S1_DATA, S0_DATA};

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expectation that depends on whether the default slave is built in.
    function automatic logic [31:0] pick(input logic [31:0] with_def, input logic [31:0] no_def);
        return DEF_EN ? with_def : no_def;
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET      = 1'b1;
        HADDR       = 32'h4000_0000;
        HTRANS      = 2'b00;
        HREADYOUT_S = 3'b111;
        HRESP_S     = 3'b000;
        #1;
        // Reset state; HSEL still decodes.
        chk("rst_hsel_s1", 32'(HSEL), 32'h2);
        chk("rst_hready", 32'(HREADY), 32'h1);
        chk("rst_hresp", 32'(HRESP), 32'h0);
        chk("rst_hrdata", HRDATA, pick(32'h0, S0_DATA));
        HADDR = 32'h0000_0000;
        #1;
        chk("rst_hsel_s0", 32'(HSEL), 32'h1);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;

        // Mapped read of slave 1.
        HADDR  = 32'h4000_0000;
        HTRANS = 2'b10;
        #1;
        chk("map_hsel", 32'(HSEL), 32'h2);
        tick();
        HTRANS = 2'b00;
        #1;
        chk("map_hrdata", HRDATA, S1_DATA);
        chk("map_hready", 32'(HREADY), 32'h1);
        HREADYOUT_S[1] = 1'b0;
        #1;
        chk("map_hready_follow", 32'(HREADY), 32'h0);
        HRESP_S[1] = 1'b1;
        #1;
        chk("map_hresp_pass", 32'(HRESP), 32'h1);
        HREADYOUT_S[1] = 1'b1;
        HRESP_S[1]     = 1'b0;

        // Wait states from slave 2 while a slave-0 address is presented.
        HADDR  = 32'h8000_0000;
        HTRANS = 2'b10;
        tick();
        HADDR          = 32'h0000_0010;
        HREADYOUT_S[2] = 1'b0;
        #1;
        chk("ws_hready", 32'(HREADY), 32'h0);
        chk("ws_hrdata", HRDATA, S2_DATA);
        tick();
        chk("ws_hold1", HRDATA, S2_DATA);
        tick();
        chk("ws_hold2", HRDATA, S2_DATA);
        HREADYOUT_S[2] = 1'b1;
        #1;
        chk("ws_release_hready", 32'(HREADY), 32'h1);
        chk("ws_release_hrdata", HRDATA, S2_DATA);
        tick();
        chk("ws_switch_s0", HRDATA, S0_DATA);

        // Unmapped NONSEQ.
        HADDR  = 32'hC000_0000;
        HTRANS = 2'b10;
        #1;
        chk("unm_hsel", 32'(HSEL), pick(32'h0, 32'h1));
        tick();
        HTRANS = 2'b00;
        HADDR  = 32'h0000_0000;
        #1;
        chk("unm_c1_hready", 32'(HREADY), pick(32'h0, 32'h1));
        chk("unm_c1_hresp", 32'(HRESP), pick(32'h1, 32'h0));
        chk("unm_c1_hrdata", HRDATA, pick(32'h0, S0_DATA));
        tick();
        chk("unm_c2_hready", 32'(HREADY), 32'h1);
        chk("unm_c2_hresp", 32'(HRESP), pick(32'h1, 32'h0));
        tick();
        chk("unm_after_hready", 32'(HREADY), 32'h1);
        chk("unm_after_hresp", 32'(HRESP), 32'h0);
        chk("unm_after_hrdata", HRDATA, S0_DATA);

        // Back-to-back unmapped NONSEQ, then a mapped access accepted in ERR2.
        HADDR  = 32'hC000_0000;
        HTRANS = 2'b10;
        tick();
        chk("b2b_e1_hready", 32'(HREADY), pick(32'h0, 32'h1));
        tick();
        chk("b2b_e2_hready", 32'(HREADY), 32'h1);
        chk("b2b_e2_hresp", 32'(HRESP), pick(32'h1, 32'h0));
        tick();
        chk("b2b_re1_hready", 32'(HREADY), pick(32'h0, 32'h1));
        chk("b2b_re1_hresp", 32'(HRESP), pick(32'h1, 32'h0));
        HTRANS = 2'b00;
        HADDR  = 32'h4000_0000;
        tick();
        chk("b2b_re2_hready", 32'(HREADY), 32'h1);
        chk("b2b_re2_hresp", 32'(HRESP), pick(32'h1, 32'h0));
        tick();
        chk("err2_map_hrdata", HRDATA, S1_DATA);
        chk("err2_map_hresp", 32'(HRESP), 32'h0);

        // Unmapped IDLE and BUSY complete with OKAY and no wait states.
        HADDR  = 32'hC000_0000;
        HTRANS = 2'b00;
        tick();
        chk("unm_idle_hready", 32'(HREADY), 32'h1);
        chk("unm_idle_hresp", 32'(HRESP), 32'h0);
        chk("unm_idle_hrdata", HRDATA, pick(32'h0, S0_DATA));
        HTRANS = 2'b01;
        tick();
        chk("unm_busy_hready", 32'(HREADY), 32'h1);
        chk("unm_busy_hresp", 32'(HRESP), 32'h0);

        // Asynchronous reset during ERR1.
        HTRANS = 2'b10;
        tick();
        HTRANS = 2'b00;
        #1;
        chk("rerr_pre_hready", 32'(HREADY), pick(32'h0, 32'h1));
        HRESET = 1'b1;
        #1;
        chk("rerr_hready", 32'(HREADY), 32'h1);
        chk("rerr_hresp", 32'(HRESP), 32'h0);
        chk("rerr_hrdata", HRDATA, pick(32'h0, S0_DATA));
        @(negedge HCLK);
        HRESET = 1'b0;
        tick();
        chk("post_rst_hready", 32'(HREADY), 32'h1);
        chk("post_rst_hresp", 32'(HRESP), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
